// File: rtl/addshare_pkg.sv
// Shared types and helpers for the adder-sharing arbiter.
package addshare_pkg;

  localparam int unsigned ADD_W     = 12;
  localparam int unsigned ADD_IN_W  = 2 * ADD_W;
  localparam int unsigned ADD_OUT_W = ADD_W + 1;
  localparam int unsigned MAX_ID_W  = 3;

  typedef struct packed {
    logic [ADD_W-1:0]    sum;
    logic                cout;
    logic [MAX_ID_W-1:0] id;
  } rsp_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  // Bit-interleave operands into the adder's input layout: {.., b1, a1, b0, a0}.
  function automatic logic [ADD_IN_W-1:0] interleave(input logic [ADD_W-1:0] a,
                                                     input logic [ADD_W-1:0] b);
    logic [ADD_IN_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < ADD_W; i++) begin
      r[2*i]   = a[i];
      r[2*i+1] = b[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic        found;
  int unsigned idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one external 12-bit adder with a one-entry response slot.
// Optional per-requester accept counters when ADDSHARE_PERF_EN is defined.
module adder_share_arbiter
  import addshare_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef ADDSHARE_PERF_EN
  input  logic                     perf_clr,
  output logic [NUM_REQ*16-1:0]    perf_grant_cnt,
`endif
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*ADD_W-1:0] req_a,
  input  logic [NUM_REQ*ADD_W-1:0] req_b,
  output logic [ADD_IN_W-1:0]      add_in,
  input  logic [ADD_OUT_W-1:0]     add_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ADD_W-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic [ID_W-1:0]          rsp_id
);

  slot_state_e          state_q, state_d;
  rsp_t                 rsp_q, rsp_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 can_issue;
  logic                 accept;
  logic [NUM_REQ-1:0]   gnt;
  logic [ID_W-1:0]      gnt_idx;
  logic [ADD_W-1:0]     sel_a, sel_b;
  logic                 unused_id;

  assign can_issue = (state_q == EMPTY) | rsp_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (can_issue),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;

  // One-hot operand mux; zero when nothing is granted.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_a = req_a[k*ADD_W +: ADD_W];
        sel_b = req_b[k*ADD_W +: ADD_W];
      end
    end
  end

  assign add_in = interleave(sel_a, sel_b);

  always_comb begin
    state_d  = state_q;
    rsp_d    = rsp_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      state_d    = FULL;
      rsp_d.sum  = add_out[ADD_W-1:0];
      rsp_d.cout = add_out[ADD_W];
      rsp_d.id   = MAX_ID_W'(gnt_idx);
      rr_ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      rsp_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rsp_q    <= rsp_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_sum   = rsp_q.sum;
  assign rsp_cout  = rsp_q.cout;
  assign rsp_id    = rsp_q.id[ID_W-1:0];
  assign unused_id = ^rsp_q.id;

`ifdef ADDSHARE_PERF_EN
  // Saturating accept counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant_cnt <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (perf_clr) begin
          perf_grant_cnt[k*16 +: 16] <= 16'h0000;
        end else if (gnt[k] && (perf_grant_cnt[k*16 +: 16] != 16'hFFFF)) begin
          perf_grant_cnt[k*16 +: 16] <= perf_grant_cnt[k*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule
